// File: rtl/elevator_car_model_pkg.sv
// Shared command encodings, fault codes and FSM state type for the elevator car model.
// Latency: n/a (constants and one pure function).
// Backpressure: n/a.
package elevator_car_model_pkg;

  // engine command
  localparam logic [1:0] ENG_STOP    = 2'b00;
  localparam logic [1:0] ENG_UP      = 2'b01;
  localparam logic [1:0] ENG_DOWN    = 2'b10;
  localparam logic [1:0] ENG_ILLEGAL = 2'b11;

  // door command
  localparam logic [1:0] DOOR_HOLD    = 2'b00;
  localparam logic [1:0] DOOR_OPEN    = 2'b01;
  localparam logic [1:0] DOOR_CLOSE   = 2'b10;
  localparam logic [1:0] DOOR_ILLEGAL = 2'b11;

  // fault codes
  localparam logic [1:0] FLT_NONE       = 2'b00;
  localparam logic [1:0] FLT_INTERLOCK  = 2'b01;
  localparam logic [1:0] FLT_OVERTRAVEL = 2'b10;
  localparam logic [1:0] FLT_ILLEGAL    = 2'b11;

  typedef enum logic {
    ST_RUN   = 1'b0,
    ST_FAULT = 1'b1
  } state_t;

  // Resolve simultaneous causes: illegal encoding beats interlock beats overtravel.
  function automatic logic [1:0] fault_priority(input logic illegal_cmd,
                                                input logic interlock,
                                                input logic overtravel);
    if (illegal_cmd)     return FLT_ILLEGAL;
    else if (interlock)  return FLT_INTERLOCK;
    else if (overtravel) return FLT_OVERTRAVEL;
    else                 return FLT_NONE;
  endfunction

endpackage

// File: rtl/car_door_model.sv
// Door actuator: saturating stroke counter 0..DOOR_TICKS with closed/open status.
// Latency: status reflects the position after the edge that sampled the command.
// Backpressure: none; freeze=1 holds the door position regardless of the command.
// Ports: clk, reset (async, active-high), door[1:0] command, freeze,
//        door_closed (position 0), door_open (position DOOR_TICKS).
module car_door_model
  import elevator_car_model_pkg::*;
#(
  parameter int DOOR_TICKS = 3
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] door,
  input  logic       freeze,
  output logic       door_closed,
  output logic       door_open
);

  localparam int                DPOS_W   = $clog2(DOOR_TICKS + 1);
  localparam logic [DPOS_W-1:0] DPOS_MAX = DPOS_W'(DOOR_TICKS);

  logic [DPOS_W-1:0] dpos;
  logic [DPOS_W-1:0] dpos_nxt;

  always_comb begin
    dpos_nxt = dpos;
    if (!freeze) begin
      case (door)
        DOOR_OPEN:  if (dpos != DPOS_MAX) dpos_nxt = dpos + DPOS_W'(1);
        DOOR_CLOSE: if (dpos != '0)       dpos_nxt = dpos - DPOS_W'(1);
        DOOR_HOLD:  dpos_nxt = dpos;
        default:    dpos_nxt = dpos;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) dpos <= '0;
    else       dpos <= dpos_nxt;
  end

  assign door_closed = (dpos == '0);
  assign door_open   = (dpos == DPOS_MAX);

endmodule

// File: rtl/elevator_car_model.sv
// Plant model of elevator car, shaft and door; closes the loop around the controller and latches unsafe commands as a fault.
// Latency: all outputs reflect state after the edge that sampled engine/door (1 cycle).
// Backpressure: none; in FAULT every input is ignored and outputs freeze until reset.
// Ports: clk, reset (async, active-high), engine[1:0], door[1:0] in;
//        level, at_floor, floor_sensor, moving, door_closed, door_open, fault, fault_code out.
module elevator_car_model
  import elevator_car_model_pkg::*;
#(
  parameter int FLOORS      = 8,
  parameter int LEVEL_WIDTH = 3,
  parameter int FLOOR_TICKS = 4,
  parameter int DOOR_TICKS  = 3
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [1:0]             engine,
  input  logic [1:0]             door,
  output logic [LEVEL_WIDTH-1:0] level,
  output logic                   at_floor,
  output logic [FLOORS-1:0]      floor_sensor,
  output logic                   moving,
  output logic                   door_closed,
  output logic                   door_open,
  output logic                   fault,
  output logic [1:0]             fault_code
);

  localparam int                     OFF_W     = $clog2(FLOOR_TICKS);
  localparam logic [OFF_W-1:0]       OFF_MAX   = OFF_W'(FLOOR_TICKS - 1);
  localparam logic [LEVEL_WIDTH-1:0] LEVEL_TOP = LEVEL_WIDTH'(FLOORS - 1);

  state_t                 state, state_nxt;
  logic [OFF_W-1:0]       offset, offset_nxt;
  logic [LEVEL_WIDTH-1:0] level_nxt;
  logic                   moving_nxt;
  logic [1:0]             code_nxt;
  logic                   illegal_cmd, interlock, overtravel;
  logic [1:0]             cause;

  // Safety checks use the sampled command against the pre-edge position.
  // door_closed is a pure decode of the door register, so it stands in for dpos==0.
  assign illegal_cmd = (engine == ENG_ILLEGAL) || (door == DOOR_ILLEGAL);
  assign interlock   = ((engine != ENG_STOP) && !door_closed) ||
                       ((door == DOOR_OPEN) && ((offset != '0) || (engine != ENG_STOP)));
  assign overtravel  = (offset == '0) &&
                       (((engine == ENG_UP)   && (level == LEVEL_TOP)) ||
                        ((engine == ENG_DOWN) && (level == '0)));
  assign cause       = fault_priority(illegal_cmd, interlock, overtravel);

  always_comb begin
    state_nxt  = state;
    level_nxt  = level;
    offset_nxt = offset;
    moving_nxt = moving;
    code_nxt   = fault_code;
    case (state)
      ST_RUN: begin
        moving_nxt = 1'b0;
        if (cause != FLT_NONE) begin
          // Offending motion is dropped; car and door hold on this edge.
          state_nxt = ST_FAULT;
          code_nxt  = cause;
        end else begin
          case (engine)
            ENG_UP: begin
              moving_nxt = 1'b1;
              if (offset == OFF_MAX) begin
                level_nxt  = level + LEVEL_WIDTH'(1);
                offset_nxt = '0;
              end else begin
                offset_nxt = offset + OFF_W'(1);
              end
            end
            ENG_DOWN: begin
              moving_nxt = 1'b1;
              if (offset == '0) begin
                level_nxt  = level - LEVEL_WIDTH'(1);
                offset_nxt = OFF_MAX;
              end else begin
                offset_nxt = offset - OFF_W'(1);
              end
            end
            default: ;
          endcase
        end
      end
      default: ; // FAULT is sticky: everything holds
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= ST_RUN;
      level      <= '0;
      offset     <= '0;
      moving     <= 1'b0;
      fault_code <= FLT_NONE;
    end else begin
      state      <= state_nxt;
      level      <= level_nxt;
      offset     <= offset_nxt;
      moving     <= moving_nxt;
      fault_code <= code_nxt;
    end
  end

  assign fault    = (state == ST_FAULT);
  assign at_floor = (offset == '0);

  always_comb begin
    floor_sensor = '0;
    for (int i = 0; i < FLOORS; i++) begin
      floor_sensor[i] = at_floor && (level == LEVEL_WIDTH'(i));
    end
  end

  car_door_model #(
    .DOOR_TICKS(DOOR_TICKS)
  ) u_door (
    .clk        (clk),
    .reset      (reset),
    .door       (door),
    .freeze     (fault || (cause != FLT_NONE)),
    .door_closed(door_closed),
    .door_open  (door_open)
  );

endmodule

// File: tb/tb_elevator_car_model.sv
// Scoreboard bench for elevator_car_model: directed commands push hand-computed expectations,
// a monitor pops and compares one entry per clock edge.
module tb_elevator_car_model;
  import elevator_car_model_pkg::*;

  logic       clk   = 1'b0;
  logic       reset = 1'b1;
  logic [1:0] engine = ENG_STOP;
  logic [1:0] door   = DOOR_HOLD;
  logic [2:0] level;
  logic       at_floor;
  logic [7:0] floor_sensor;
  logic       moving;
  logic       door_closed;
  logic       door_open;
  logic       fault;
  logic [1:0] fault_code;

  always #5 clk = ~clk;

  elevator_car_model #(
    .FLOORS(8), .LEVEL_WIDTH(3), .FLOOR_TICKS(4), .DOOR_TICKS(3)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .engine      (engine),
    .door        (door),
    .level       (level),
    .at_floor    (at_floor),
    .floor_sensor(floor_sensor),
    .moving      (moving),
    .door_closed (door_closed),
    .door_open   (door_open),
    .fault       (fault),
    .fault_code  (fault_code)
  );

  typedef struct {
    string nm;
    int    lv;
    bit    af;
    bit    mv;
    bit    dc;
    bit    dop;
    bit    flt;
    int    fc;
  } exp_t;

  exp_t sb_q[$];
  exp_t mon_x;
  int   n_tests = 0;
  int   n_fail  = 0;

  task automatic chk(input string nm, input string fld, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s.%s: got %0d, expected %0d", nm, fld, act, exp);
    end
  endtask

  function automatic logic [7:0] onehot(input int lv, input bit af);
    logic [7:0] v;
    v = '0;
    if (af) v[lv] = 1'b1;
    return v;
  endfunction

  // Drive one command at the falling edge and queue what the next rising edge must produce.
  task automatic step(input string nm, input logic [1:0] e, input logic [1:0] d,
                      input int lv, input bit af, input bit mv, input bit dc,
                      input bit dop, input bit flt, input int fc);
    exp_t x;
    @(negedge clk);
    engine = e;
    door   = d;
    x.nm = nm; x.lv = lv; x.af = af; x.mv = mv;
    x.dc = dc; x.dop = dop; x.flt = flt; x.fc = fc;
    sb_q.push_back(x);
  endtask

  // Assert reset between edges and require reset values before the next rising edge.
  task automatic reset_check(input string nm);
    @(posedge clk);
    #3;
    reset  = 1'b1;
    engine = ENG_STOP;
    door   = DOOR_HOLD;
    #1;
    chk(nm, "level",        32'(level),        0);
    chk(nm, "at_floor",     32'(at_floor),     1);
    chk(nm, "floor_sensor", 32'(floor_sensor), 1);
    chk(nm, "moving",       32'(moving),       0);
    chk(nm, "door_closed",  32'(door_closed),  1);
    chk(nm, "door_open",    32'(door_open),    0);
    chk(nm, "fault",        32'(fault),        0);
    chk(nm, "fault_code",   32'(fault_code),   0);
    @(negedge clk);
    reset = 1'b0;
  endtask

  always @(posedge clk) begin
    #1;
    if (sb_q.size() != 0) begin
      mon_x = sb_q.pop_front();
      chk(mon_x.nm, "level",        32'(level),        32'(mon_x.lv));
      chk(mon_x.nm, "at_floor",     32'(at_floor),     32'(mon_x.af));
      chk(mon_x.nm, "floor_sensor", 32'(floor_sensor), 32'(onehot(mon_x.lv, mon_x.af)));
      chk(mon_x.nm, "moving",       32'(moving),       32'(mon_x.mv));
      chk(mon_x.nm, "door_closed",  32'(door_closed),  32'(mon_x.dc));
      chk(mon_x.nm, "door_open",    32'(door_open),    32'(mon_x.dop));
      chk(mon_x.nm, "fault",        32'(fault),        32'(mon_x.flt));
      chk(mon_x.nm, "fault_code",   32'(fault_code),   32'(mon_x.fc));
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation exceeded time limit, tests=%0d failed=%0d", n_tests, n_fail);
    $fatal(1, "watchdog");
  end

  initial begin
    reset_check("rst_init");

    // Two floors up: offsets 1,2,3,0 per floor, moving on every edge.
    for (int i = 1; i <= 8; i++)
      step("up8", ENG_UP, DOOR_HOLD, i / 4, (i % 4) == 0, 1, 1, 0, 0, 0);
    step("stop_l2", ENG_STOP, DOOR_HOLD, 2, 1, 0, 1, 0, 0, 0);

    // Full door cycle at level 2.
    step("open1", ENG_STOP, DOOR_OPEN,  2, 1, 0, 0, 0, 0, 0);
    step("open2", ENG_STOP, DOOR_OPEN,  2, 1, 0, 0, 0, 0, 0);
    step("open3", ENG_STOP, DOOR_OPEN,  2, 1, 0, 0, 1, 0, 0);
    for (int i = 0; i < 5; i++)
      step("hold", ENG_STOP, DOOR_HOLD, 2, 1, 0, 0, 1, 0, 0);
    step("close1", ENG_STOP, DOOR_CLOSE, 2, 1, 0, 0, 0, 0, 0);
    step("close2", ENG_STOP, DOOR_CLOSE, 2, 1, 0, 0, 0, 0, 0);
    step("close3", ENG_STOP, DOOR_CLOSE, 2, 1, 0, 1, 0, 0, 0);
    step("close_sat", ENG_STOP, DOOR_CLOSE, 2, 1, 0, 1, 0, 0, 0);

    // Reverse mid-floor and cross back below level 2.
    step("up_a",   ENG_UP,   DOOR_HOLD, 2, 0, 1, 1, 0, 0, 0);
    step("up_b",   ENG_UP,   DOOR_HOLD, 2, 0, 1, 1, 0, 0, 0);
    step("down_a", ENG_DOWN, DOOR_HOLD, 2, 0, 1, 1, 0, 0, 0);
    step("down_b", ENG_DOWN, DOOR_HOLD, 2, 1, 1, 1, 0, 0, 0);
    step("down_c", ENG_DOWN, DOOR_HOLD, 1, 0, 1, 1, 0, 0, 0);
    step("up_c",   ENG_UP,   DOOR_HOLD, 2, 1, 1, 1, 0, 0, 0);

    // Interlock: motor command with door fully open, then sticky fault.
    step("reopen1", ENG_STOP, DOOR_OPEN, 2, 1, 0, 0, 0, 0, 0);
    step("reopen2", ENG_STOP, DOOR_OPEN, 2, 1, 0, 0, 0, 0, 0);
    step("reopen3", ENG_STOP, DOOR_OPEN, 2, 1, 0, 0, 1, 0, 0);
    step("ilk_up",  ENG_UP,   DOOR_HOLD, 2, 1, 0, 0, 1, 1, 1);
    step("sticky1", ENG_DOWN, DOOR_CLOSE, 2, 1, 0, 0, 1, 1, 1);
    step("sticky2", ENG_ILLEGAL, DOOR_CLOSE, 2, 1, 0, 0, 1, 1, 1);
    step("sticky3", ENG_STOP, DOOR_CLOSE, 2, 1, 0, 0, 1, 1, 1);
    reset_check("rst_after_ilk");

    // Overtravel below level 0.
    step("ovt_down", ENG_DOWN, DOOR_HOLD, 0, 1, 0, 1, 0, 1, 2);
    step("ovt_hold", ENG_UP,   DOOR_HOLD, 0, 1, 0, 1, 0, 1, 2);
    reset_check("rst_after_ovt");

    // Illegal engine with door OPEN mid-floor: illegal wins over interlock.
    step("mid_up",   ENG_UP,      DOOR_HOLD, 0, 0, 1, 1, 0, 0, 0);
    step("ill_prio", ENG_ILLEGAL, DOOR_OPEN, 0, 0, 0, 1, 0, 1, 3);
    reset_check("rst_after_ill");

    // Door OPEN between floors with the motor stopped is an interlock.
    step("mid_up2",  ENG_UP,   DOOR_HOLD, 0, 0, 1, 1, 0, 0, 0);
    step("ilk_door", ENG_STOP, DOOR_OPEN, 0, 0, 0, 1, 0, 1, 1);
    reset_check("rst_after_ilk2");

    // Travel to level 5 offset 2, then reset between edges.
    for (int i = 1; i <= 22; i++)
      step("up22", ENG_UP, DOOR_HOLD, i / 4, (i % 4) == 0, 1, 1, 0, 0, 0);
    reset_check("rst_midtravel");

    // Partial door stroke, then reset between edges.
    step("stroke1", ENG_STOP, DOOR_OPEN, 0, 1, 0, 0, 0, 0, 0);
    step("stroke2", ENG_STOP, DOOR_OPEN, 0, 1, 0, 0, 0, 0, 0);
    reset_check("rst_midstroke");

    for (int i = 0; i < 10 && sb_q.size() != 0; i++) @(posedge clk);
    #2;
    chk("drain", "queue_left", 32'(sb_q.size()), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
